// File: rtl/spdif_pkg.sv
// spdif_pkg: shared types and constants for the S/PDIF subframe unpacker.
//   pre_t         : preamble code delivered with sof (B, M, W, invalid)
//   slot constants: bit positions inside the 28-bit subframe, bit 0 = first bit received
//   state_t       : unpacker FSM states
package spdif_pkg;

  typedef enum logic [1:0] {
    PRE_B = 2'd0,
    PRE_M = 2'd1,
    PRE_W = 2'd2,
    PRE_X = 2'd3
  } pre_t;

  localparam int AUX_LSB       = 0;
  localparam int AUD_LSB       = 4;
  localparam int V_BIT         = 24;
  localparam int U_BIT         = 25;
  localparam int C_BIT         = 26;
  localparam int P_BIT         = 27;
  localparam int SUBFRAME_BITS = 28;
  localparam int BIT_CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Even parity over the whole subframe (P included) gives zero.
  function automatic logic subframe_parity_ok(input logic [SUBFRAME_BITS-1:0] w);
    return ~(^w);
  endfunction

endpackage

// File: rtl/spdif_chstat_capture.sv
// spdif_chstat_capture: assembles the channel-status block from the C bits of
// channel-0 subframes.
//   clk, rst_n  : clock, synchronous active-low reset
//   wr_i        : one-cycle strobe, a good-parity channel-0 subframe is in CHECK
//   bstart_i    : that subframe carried a B preamble (block start)
//   cbit_i      : its C bit
//   cs_data_o   : last complete block, bit 0 = first frame of the block
//   cs_valid_o  : one-cycle pulse when cs_data_o is refreshed
module spdif_chstat_capture
  import spdif_pkg::*;
#(
  parameter int CS_BITS = 192,
  parameter int CNT_W   = (CS_BITS > 1) ? $clog2(CS_BITS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_i,
  input  logic               bstart_i,
  input  logic               cbit_i,
  output logic [CS_BITS-1:0] cs_data_o,
  output logic               cs_valid_o
);

  logic [CS_BITS-1:0] shadow_q;
  logic [CS_BITS-1:0] shadow_d;
  logic [CS_BITS-1:0] cs_data_q;
  logic               cs_valid_q;
  logic [CNT_W-1:0]   cs_cnt_q;
  logic [CNT_W-1:0]   idx_d;
  logic               last_d;

  // A B preamble restarts the block at slot 0; any partial block is simply
  // overwritten, so stale shadow bits never reach cs_data.
  always_comb begin
    idx_d           = bstart_i ? '0 : cs_cnt_q;
    shadow_d        = shadow_q;
    shadow_d[idx_d] = cbit_i;
    last_d          = (idx_d == CNT_W'(CS_BITS - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q   <= '0;
      cs_data_q  <= '0;
      cs_valid_q <= 1'b0;
      cs_cnt_q   <= '0;
    end else begin
      cs_valid_q <= 1'b0;
      if (wr_i) begin
        shadow_q <= shadow_d;
        if (last_d) begin
          cs_data_q  <= shadow_d;
          cs_valid_q <= 1'b1;
          cs_cnt_q   <= '0;
        end else begin
          cs_cnt_q <= idx_d + 1'b1;
        end
      end
    end
  end

  assign cs_data_o  = cs_data_q;
  assign cs_valid_o = cs_valid_q;

endmodule

// File: rtl/spdif_subframe_unpack.sv
// spdif_subframe_unpack: turns the decoded S/PDIF bit stream into samples.
//   clk, rst_n         : clock, synchronous active-low reset
//   sof, pre           : start-of-subframe strobe and preamble code (pre_t)
//   vin, din           : bit qualifier and subframe bit, first bit = slot 0 of the map
//   out_data/out_ch    : sample (SAMPLE_W) and channel index (CH_W)
//   out_vflag/out_ublk : V and U bits, out_bstart = subframe began with B
//   out_valid/out_ready: one-deep output register handshake
//   cs_data/cs_valid   : channel-status block capture
//   parity_err/ovf_err/frame_err : sticky flags, cleared by err_clr (a set wins)
// Optional feature macro: CHSTAT_CAPTURE_EN enables channel-status capture;
// without it cs_data and cs_valid are tied to 0.
module spdif_subframe_unpack
  import spdif_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int NUM_CH   = 2,
  parameter int CS_BITS  = 192,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sof,
  input  logic [1:0]          pre,
  input  logic                vin,
  input  logic                din,
  output logic [SAMPLE_W-1:0] out_data,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_vflag,
  output logic                out_ublk,
  output logic                out_bstart,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CS_BITS-1:0]  cs_data,
  output logic                cs_valid,
  output logic                parity_err,
  output logic                ovf_err,
  output logic                frame_err,
  input  logic                err_clr
);

  state_t                   state_q;
  pre_t                     pre_q;
  logic [SUBFRAME_BITS-1:0] sr_q;
  logic [BIT_CNT_W-1:0]     bit_cnt_q;
  logic [CH_W-1:0]          ch_idx_q;

  logic [SAMPLE_W-1:0]      out_data_q;
  logic [CH_W-1:0]          out_ch_q;
  logic                     out_vflag_q;
  logic                     out_ublk_q;
  logic                     out_bstart_q;
  logic                     out_valid_q;
  logic                     parity_err_q;
  logic                     ovf_err_q;
  logic                     frame_err_q;

  logic                     in_check_d;
  logic                     parity_ok_d;
  logic [CH_W-1:0]          ch_next_d;
  logic                     load_d;
  logic                     par_set_d;
  logic                     ovf_set_d;
  logic                     frm_set_d;
  logic [SAMPLE_W-1:0]      sample_d;

  // Sample is MSB-aligned on the audio field: 20 bits = audio only,
  // 24 bits = audio followed by aux. Wider samples are zero padded below.
  if (SAMPLE_W <= 24) begin : g_sample_narrow
    assign sample_d = sr_q[AUD_LSB+19 -: SAMPLE_W];
  end else begin : g_sample_wide
    assign sample_d = {sr_q[AUD_LSB+19:AUX_LSB], {(SAMPLE_W-24){1'b0}}};
  end

  always_comb begin
    in_check_d  = (state_q == ST_CHECK);
    parity_ok_d = subframe_parity_ok(sr_q);
    ch_next_d   = '0;
    if (pre_q == PRE_W) begin
      ch_next_d = (ch_idx_q == CH_W'(NUM_CH - 1)) ? '0 : ch_idx_q + 1'b1;
    end
    load_d    = in_check_d & parity_ok_d & (~out_valid_q | out_ready);
    ovf_set_d = in_check_d & parity_ok_d & out_valid_q & ~out_ready;
    par_set_d = in_check_d & ~parity_ok_d;
    // Any sof while shifting aborts the subframe; in IDLE only an invalid
    // preamble is an error. A sof during CHECK is outside the timing envelope
    // and is ignored.
    frm_set_d = sof & (((state_q == ST_IDLE) & (pre == PRE_X)) | (state_q == ST_SHIFT));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pre_q        <= PRE_B;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      ch_idx_q     <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_vflag_q  <= 1'b0;
      out_ublk_q   <= 1'b0;
      out_bstart_q <= 1'b0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      ovf_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      parity_err_q <= par_set_d | (parity_err_q & ~err_clr);
      ovf_err_q    <= ovf_set_d | (ovf_err_q & ~err_clr);
      frame_err_q  <= frm_set_d | (frame_err_q & ~err_clr);

      case (state_q)
        ST_IDLE, ST_SHIFT: begin
          if (sof) begin
            bit_cnt_q <= '0;
            if (pre != PRE_X) begin
              state_q <= ST_SHIFT;
              pre_q   <= pre_t'(pre);
            end else begin
              state_q <= ST_IDLE;
            end
          end else if ((state_q == ST_SHIFT) && vin) begin
            // First bit ends up in sr_q[0] after 28 shifts.
            sr_q      <= {din, sr_q[SUBFRAME_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_CNT_W'(SUBFRAME_BITS - 1)) begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          // Channel advances even when the sample is dropped.
          ch_idx_q  <= ch_next_d;
          bit_cnt_q <= '0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (load_d) begin
        out_data_q   <= sample_d;
        out_ch_q     <= ch_next_d;
        out_vflag_q  <= sr_q[V_BIT];
        out_ublk_q   <= sr_q[U_BIT];
        out_bstart_q <= (pre_q == PRE_B);
        out_valid_q  <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_vflag  = out_vflag_q;
  assign out_ublk   = out_ublk_q;
  assign out_bstart = out_bstart_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign ovf_err    = ovf_err_q;
  assign frame_err  = frame_err_q;

`ifdef CHSTAT_CAPTURE_EN
  logic cs_wr_d;
  assign cs_wr_d = in_check_d & parity_ok_d & (ch_next_d == '0);

  spdif_chstat_capture #(
    .CS_BITS (CS_BITS)
  ) u_chstat (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_i       (cs_wr_d),
    .bstart_i   (pre_q == PRE_B),
    .cbit_i     (sr_q[C_BIT]),
    .cs_data_o  (cs_data),
    .cs_valid_o (cs_valid)
  );
`else
  assign cs_data  = '0;
  assign cs_valid = 1'b0;
`endif

endmodule
